// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative unsigned multiply/divide unit for the Execute stage. It handles
//   MUL, MULHU, DIVU and REMU with a radix-2 shift-add multiplier or a
//   restoring divider, and retires one bit per cycle. While an operation is
//   in flight it requests a pipeline stall.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-high; returns the unit to IDLE
//   startE   in   E-stage instruction is a mul/div op
//   opE      in   operation select (OP_* encodings)
//   srcAE    in   operand A (multiplicand / dividend)
//   srcBE    in   operand B (multiplier / divisor)
//   flushE   in   synchronous abort of the E stage (wins over startE)
//   stallE   out  stall request to the hazard unit (combinational)
//   doneE    out  one-cycle pulse, resultE valid (registered)
//   resultE  out  operation result (registered, held until next capture)
//
// Handshake: startE acts as a level request. It is accepted in IDLE when
// flushE is low. stallE stays high until the DONE cycle, and doneE marks that
// cycle. In DONE, startE is ignored because the finishing instruction is
// still sitting in ID/EX.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic [1:0]      opE,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic            flushE,
  output logic            stallE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, stateNext;

  logic [CW-1:0]     counter;
  logic [1:0]        opReg;

  // Multiplier datapath: the multiplicand shifts left and the multiplier
  // shifts right, so bit 0 of mplier is always the current multiplier bit.
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mplier;

  // Divider datapath: quot starts as the dividend. Its MSBs shift out into
  // the remainder while the quotient bits shift in at the bottom.
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  logic [2*XLEN-1:0] prodNext;
  logic [XLEN:0]     remShift;
  logic [XLEN:0]     trialDiff;
  logic [XLEN-1:0]   remNext;
  logic [XLEN-1:0]   quotNext;
  logic [XLEN-1:0]   finalResult;
  logic              divZero;
  logic              lastIter;
  logic              accept;

  assign accept   = startE && !flushE;
  assign divZero  = opE[1] && (srcBE == '0);
  assign lastIter = (counter == CW'(XLEN - 1));

  // One iteration of each algorithm. The result is taken from these "next"
  // values on the last iteration, so resultE is already valid in DONE.
  always_comb begin
    prodNext  = mplier[0] ? (prod + mcand) : prod;
    remShift  = {rem, quot[XLEN-1]};
    trialDiff = remShift - {1'b0, divisor};
    if (!trialDiff[XLEN]) begin
      remNext  = trialDiff[XLEN-1:0];
      quotNext = {quot[XLEN-2:0], 1'b1};
    end else begin
      remNext  = remShift[XLEN-1:0];
      quotNext = {quot[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    finalResult = '0;
    case (opReg)
      OP_MUL:   finalResult = prodNext[XLEN-1:0];
      OP_MULHU: finalResult = prodNext[2*XLEN-1:XLEN];
      OP_DIVU:  finalResult = quotNext;
      OP_REMU:  finalResult = remNext;
      default:  finalResult = '0;
    endcase
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = divZero ? DONE : BUSY;
      BUSY: if (lastIter) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (flushE) stateNext = IDLE;
  end

  assign stallE = ((state == IDLE) && accept) || (state == BUSY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      opReg   <= OP_MUL;
      mcand   <= '0;
      prod    <= '0;
      mplier  <= '0;
      divisor <= '0;
      quot    <= '0;
      rem     <= '0;
      doneE   <= 1'b0;
      resultE <= '0;
    end else begin
      state <= stateNext;
      doneE <= (stateNext == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            opReg   <= opE;
            mcand   <= {{XLEN{1'b0}}, srcAE};
            mplier  <= srcBE;
            prod    <= '0;
            divisor <= srcBE;
            quot    <= srcAE;
            rem     <= '0;
            counter <= '0;
            // Division by zero: quotient is all ones, remainder is the dividend.
            if (divZero) resultE <= opE[0] ? srcAE : '1;
          end
        end
        BUSY: begin
          if (!flushE) begin
            counter <= counter + 1'b1;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            prod    <= prodNext;
            rem     <= remNext;
            quot    <= quotNext;
            if (lastIter) resultE <= finalResult;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            startE;
  logic [1:0]      opE;
  logic [XLEN-1:0] srcAE;
  logic [XLEN-1:0] srcBE;
  logic            flushE;
  logic            stallE;
  logic            doneE;
  logic [XLEN-1:0] resultE;

  int checks;
  int failures;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .startE  (startE),
    .opE     (opE),
    .srcAE   (srcAE),
    .srcBE   (srcBE),
    .flushE  (flushE),
    .stallE  (stallE),
    .doneE   (doneE),
    .resultE (resultE)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    startE = 1'b0;
    flushE = 1'b0;
    opE    = 2'b00;
    srcAE  = '0;
    srcBE  = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (stallE !== 1'b0 || doneE !== 1'b0 || resultE !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: stallE=%b doneE=%b resultE=%h required 0 0 00000000",
               stallE, doneE, resultE);
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  // Holds startE until doneE appears. It checks the latency of doneE, the
  // number of stall cycles and the result, and then confirms that the unit
  // went quiet instead of restarting.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_res, input int exp_lat);
    int  stalls;
    bit  seen;
    opE    = op;
    srcAE  = a;
    srcBE  = b;
    startE = 1'b1;
    stalls = 0;
    seen   = 0;
    for (int idx = 0; idx < 40 && !seen; idx++) begin
      @(negedge clk);
      if (stallE) stalls++;
      if (doneE) begin
        seen = 1;
        checks++;
        if (idx != exp_lat) begin
          failures++;
          $display("FAIL %s_latency: doneE at T+%0d required T+%0d", name, idx, exp_lat);
        end
        checks++;
        if (resultE !== exp_res) begin
          failures++;
          $display("FAIL %s_result: resultE=%h required %h", name, resultE, exp_res);
        end
      end
      next_cycle();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: no doneE within 40 cycles", name);
    end
    checks++;
    if (stalls != exp_lat) begin
      failures++;
      $display("FAIL %s_stall_cycles: stallE high %0d cycles required %0d", name, stalls, exp_lat);
    end
    startE = 1'b0;
    @(negedge clk);
    checks++;
    if (doneE !== 1'b0 || stallE !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_after: doneE=%b stallE=%b required 0 0", name, doneE, stallE);
    end
    next_cycle();
  endtask

  task automatic test_mul();
    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000002A, 33);
    run_op("mulhu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
  endtask

  task automatic test_div();
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'h0000000E, 33);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'h00000002, 33);
    run_op("divu_msb_1", 2'b10, 32'h80000000, 32'd1, 32'h80000000, 33);
  endtask

  task automatic test_div_by_zero();
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'h00000005, 1);
  endtask

  // The previous result (5 from REMU 5/0) must survive a flush of a DIVU.
  task automatic test_flush();
    int dones;
    dones  = 0;
    opE    = 2'b10;
    srcAE  = 32'd100;
    srcBE  = 32'd7;
    startE = 1'b1;
    for (int idx = 0; idx < 10; idx++) begin
      @(negedge clk);
      if (doneE) dones++;
      next_cycle();
    end
    startE = 1'b0;
    flushE = 1'b1;
    @(negedge clk);
    next_cycle();
    flushE = 1'b0;
    @(negedge clk);
    checks++;
    if (stallE !== 1'b0 || doneE !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: stallE=%b doneE=%b required 0 0", stallE, doneE);
    end
    checks++;
    if (resultE !== 32'h00000005) begin
      failures++;
      $display("FAIL flush_result_held: resultE=%h required 00000005", resultE);
    end
    next_cycle();
    for (int idx = 0; idx < 40; idx++) begin
      @(negedge clk);
      if (doneE) dones++;
      next_cycle();
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL flush_no_done: %0d doneE pulses required 0", dones);
    end
  endtask

  task automatic test_async_reset();
    opE    = 2'b00;
    srcAE  = 32'd7;
    srcBE  = 32'd6;
    startE = 1'b1;
    for (int idx = 0; idx < 20; idx++) next_cycle();
    #2;
    reset  = 1'b1;
    startE = 1'b0;
    #1;
    checks++;
    if (stallE !== 1'b0 || doneE !== 1'b0 || resultE !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: stallE=%b doneE=%b resultE=%h required 0 0 00000000",
               stallE, doneE, resultE);
    end
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
    run_op("after_reset_mul", 2'b00, 32'd12, 32'd11, 32'h00000084, 33);
  endtask

  // startE stays high through DONE. The second op (DIVU 1000/10) is captured
  // at T+34 and completes at T+67.
  task automatic test_back_to_back();
    int dones;
    int first_at;
    int second_at;
    logic [XLEN-1:0] first_res;
    logic [XLEN-1:0] second_res;
    dones      = 0;
    first_at   = -1;
    second_at  = -1;
    first_res  = '0;
    second_res = '0;
    opE    = 2'b00;
    srcAE  = 32'd3;
    srcBE  = 32'd5;
    startE = 1'b1;
    for (int idx = 0; idx < 75; idx++) begin
      if (idx == 34) begin
        opE   = 2'b10;
        srcAE = 32'd1000;
        srcBE = 32'd10;
      end
      if (idx == 68) startE = 1'b0;
      @(negedge clk);
      if (doneE) begin
        dones++;
        if (dones == 1) begin first_at = idx; first_res = resultE; end
        if (dones == 2) begin second_at = idx; second_res = resultE; end
      end
      next_cycle();
    end
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL b2b_done_count: %0d doneE pulses required 2", dones);
    end
    checks++;
    if (first_at != 33 || first_res !== 32'd15) begin
      failures++;
      $display("FAIL b2b_first: at T+%0d result=%h required T+33 0000000f", first_at, first_res);
    end
    checks++;
    if (second_at != 67 || second_res !== 32'd100) begin
      failures++;
      $display("FAIL b2b_second: at T+%0d result=%h required T+67 00000064", second_at, second_res);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
